// File: rtl/gpio_key_in_pkg.sv
// -----------------------------------------------------------------------------
// gpio_key_in_pkg
// Shared constants for the push-button input peripheral: bus widths, register
// offsets (low nibble of the address), CTRL bit positions and the reset value
// of the debounce threshold. Also holds a helper that floors the threshold
// at 1 so a DBNC of 0 still debounces for one cycle.
// Optional feature macro: GPIO_KEY_IRQ_EN (CTRL IRQ mask bits and irq_o).
// -----------------------------------------------------------------------------
package gpio_key_in_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    localparam int KEY_NUM_DEF = 4;
    localparam int CNT_W_DEF   = 20;
    localparam logic [CNT_W_DEF-1:0] DBNC_RST_DEF = 20'd1_000_000;

    // Register offsets, decoded from address bits [3:0]
    localparam logic [3:0] KEY_CTRL  = 4'h0;
    localparam logic [3:0] KEY_DATA  = 4'h4;
    localparam logic [3:0] KEY_EVENT = 4'h8;
    localparam logic [3:0] KEY_DBNC  = 4'hC;

    // CTRL bit positions
    localparam int KEY_CTRL_EN_BIT    = 0;
    localparam int KEY_CTRL_PMASK_LSB = 4;
    localparam int KEY_CTRL_RMASK_LSB = 8;

    // Effective threshold: a programmed 0 behaves like 1.
    function automatic logic [CNT_W_DEF-1:0] dbnc_floor1(input logic [CNT_W_DEF-1:0] t);
        return (t == '0) ? CNT_W_DEF'(1) : t;
    endfunction

endpackage

// File: rtl/gpio_key_in_if.sv
// -----------------------------------------------------------------------------
// gpio_key_in_if
// Peripheral register bus shared with the LED GPIO block.
//   wr_en_i   : write strobe, one write per cycle it is high
//   wr_addr_i : write address, only [3:0] decoded
//   wr_data_i : write data
//   rd_addr_i : read address, only [3:0] decoded
//   rd_data_o : registered read data
// Handshake: there is no valid/ready pair. A write is accepted on every rising
// clk edge where wr_en_i is high; a read is always accepted and its data is on
// rd_data_o after the next rising edge. The slave never stalls.
// Modports: master (core side), slave (peripheral side).
// -----------------------------------------------------------------------------
interface gpio_key_in_if;
    import gpio_key_in_pkg::*;

    logic                   wr_en_i;
    logic [INST_ADDR_W-1:0] wr_addr_i;
    logic [INST_DATA_W-1:0] wr_data_i;
    logic [INST_ADDR_W-1:0] rd_addr_i;
    logic [INST_DATA_W-1:0] rd_data_o;

    modport master (
        output wr_en_i,
        output wr_addr_i,
        output wr_data_i,
        output rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_data_i,
        input  rd_addr_i,
        output rd_data_o
    );

endinterface

// File: rtl/gpio_key_in_key_debounce_cell.sv
// -----------------------------------------------------------------------------
// key_debounce_cell
// One key: 2-flop synchronizer followed by a debounce counter.
//   clk, rst  : clock, asynchronous active-high reset
//   en_i      : when low the counter is held at 0 and level is frozen
//   raw_i     : pressed level (1 = pressed), asynchronous to clk
//   thresh_i  : debounce threshold in cycles (0 treated as 1)
//   level_o   : debounced pressed level
//   rise_o    : 1-cycle pulse in the cycle level goes 0->1 (comb, aligned
//               with the edge that updates level_o)
//   fall_o    : 1-cycle pulse in the cycle level goes 1->0
// -----------------------------------------------------------------------------
module key_debounce_cell
    import gpio_key_in_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             raw_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o
);

    // The synchronizer carries the pin polarity (active-low) so that its
    // reset value of 1 means "released", matching an idle pulled-up pin.
    logic pin_meta_q, pin_sync_q;
    logic sync_lvl;

    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_meta_q <= 1'b1;
            pin_sync_q <= 1'b1;
        end else begin
            pin_meta_q <= ~raw_i;
            pin_sync_q <= pin_meta_q;
        end
    end

    assign sync_lvl = ~pin_sync_q;

    assign thr_eff = (thresh_i == '0) ? CNT_W'(1) : thresh_i;
    // One extra bit so the compare is exact even at the top of the range.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit     = (cnt_inc >= {1'b0, thr_eff});

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_o   = 1'b0;
        fall_o   = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (sync_lvl == stable_q) begin
            cnt_d = '0;
        end else if (hit) begin
            stable_d = sync_lvl;
            cnt_d    = '0;
            rise_o   = sync_lvl;
            fall_o   = ~sync_lvl;
        end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/gpio_key_in.sv
// -----------------------------------------------------------------------------
// gpio_key_in
// Four active-low push buttons, each synchronized and debounced, exposed
// through the GPIO peripheral register bus.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : gpio_key_in_if.slave register bus (write/read ports)
//   key_pins  : raw button pins, 0 = pressed
//   irq_o     : registered level interrupt
// Registers (address [3:0]):
//   0x0 CTRL  RW  bit0 enable; [7:4] press mask, [11:8] release mask
//                 (mask bits only with GPIO_KEY_IRQ_EN)
//   0x4 DATA  RO  [3:0] debounced pressed level
//   0x8 EVENT W1C [3:0] press-seen, [7:4] release-seen
//   0xC DBNC  RW  [CNT_W-1:0] debounce threshold
// Optional feature macro: GPIO_KEY_IRQ_EN. Without it irq_o is tied to 0.
// -----------------------------------------------------------------------------
module gpio_key_in
    import gpio_key_in_pkg::*;
#(
    parameter int               KEY_NUM  = KEY_NUM_DEF,
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DBNC_RST = DBNC_RST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    gpio_key_in_if.slave       bus,
    input  logic [KEY_NUM-1:0] key_pins,
    output logic               irq_o
);

    logic [KEY_NUM-1:0] level;
    logic [KEY_NUM-1:0] rise;
    logic [KEY_NUM-1:0] fall;

    logic               ctrl_en_q, ctrl_en_d;
    logic [2*KEY_NUM-1:0] event_q, event_d;
    logic [CNT_W-1:0]   dbnc_q, dbnc_d;
    logic [INST_DATA_W-1:0] rd_data_q, rd_data_d;

    logic wr_ctrl, wr_event, wr_dbnc;

    assign wr_ctrl  = bus.wr_en_i && (bus.wr_addr_i[3:0] == KEY_CTRL);
    assign wr_event = bus.wr_en_i && (bus.wr_addr_i[3:0] == KEY_EVENT);
    assign wr_dbnc  = bus.wr_en_i && (bus.wr_addr_i[3:0] == KEY_DBNC);

    // Debounce cells use the registered threshold/enable, so a CTRL or DBNC
    // write affects the counters from the following cycle on.
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en_i     (ctrl_en_q),
            .raw_i    (~key_pins[i]),
            .thresh_i (dbnc_q),
            .level_o  (level[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

`ifdef GPIO_KEY_IRQ_EN
    logic [KEY_NUM-1:0] pmask_q, pmask_d;
    logic [KEY_NUM-1:0] rmask_q, rmask_d;
    logic               irq_q, irq_d;

    always_comb begin
        pmask_d = pmask_q;
        rmask_d = rmask_q;
        if (wr_ctrl) begin
            pmask_d = bus.wr_data_i[KEY_CTRL_PMASK_LSB +: KEY_NUM];
            rmask_d = bus.wr_data_i[KEY_CTRL_RMASK_LSB +: KEY_NUM];
        end
    end

    // Built from the registered flags, so irq_o trails EVENT by one cycle.
    assign irq_d = (|(event_q[KEY_NUM-1:0] & pmask_q)) |
                   (|(event_q[2*KEY_NUM-1:KEY_NUM] & rmask_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmask_q <= '0;
            rmask_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            pmask_q <= pmask_d;
            rmask_q <= rmask_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        ctrl_en_d = ctrl_en_q;
        dbnc_d    = dbnc_q;
        if (wr_ctrl) begin
            ctrl_en_d = bus.wr_data_i[KEY_CTRL_EN_BIT];
        end
        if (wr_dbnc) begin
            dbnc_d = bus.wr_data_i[CNT_W-1:0];
        end
    end

    // W1C clear first, then the new pulses, so a set in the same cycle wins.
    always_comb begin
        event_d = event_q;
        if (wr_event) begin
            event_d = event_d & ~bus.wr_data_i[2*KEY_NUM-1:0];
        end
        event_d = event_d | {fall, rise};
    end

    // Read mux looks at next-state values so a same-cycle write is visible.
    always_comb begin
        rd_data_d = '0;
        case (bus.rd_addr_i[3:0])
            KEY_CTRL: begin
                rd_data_d[KEY_CTRL_EN_BIT] = ctrl_en_d;
`ifdef GPIO_KEY_IRQ_EN
                rd_data_d[KEY_CTRL_PMASK_LSB +: KEY_NUM] = pmask_d;
                rd_data_d[KEY_CTRL_RMASK_LSB +: KEY_NUM] = rmask_d;
`endif
            end
            KEY_DATA:  rd_data_d[KEY_NUM-1:0]   = level;
            KEY_EVENT: rd_data_d[2*KEY_NUM-1:0] = event_d;
            KEY_DBNC:  rd_data_d[CNT_W-1:0]     = dbnc_d;
            default:   rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q <= 1'b0;
            event_q   <= '0;
            dbnc_q    <= DBNC_RST;
            rd_data_q <= '0;
        end else begin
            ctrl_en_q <= ctrl_en_d;
            event_q   <= event_d;
            dbnc_q    <= dbnc_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data_o = rd_data_q;

    // Address bits above the offset and data bits above the widest field
    // are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.wr_addr_i[INST_ADDR_W-1:4],
                           bus.rd_addr_i[INST_ADDR_W-1:4],
                           bus.wr_data_i[INST_DATA_W-1:CNT_W]};

endmodule
